// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the SDRAM port arbiter.
package mem_arb_pkg;

    localparam int MEM_NCH  = 4;
    localparam int MEM_AW   = 22;
    localparam int MEM_DW   = 8;
    localparam int MEM_SLOT = 4;

    typedef enum logic [1:0] {INIT, IDLE, RUN} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_REF} op_t;

    function automatic op_t op_of(input logic we);
        return we ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request-side bundle: per-channel handshakes plus the refresh handshake.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NCH = MEM_NCH,
    parameter int AW  = MEM_AW,
    parameter int DW  = MEM_DW
);

    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] din;
    logic [NCH-1:0]    ack;
    logic [NCH*DW-1:0] dout;
    logic [NCH-1:0]    valid;
    logic              refresh_req;
    logic              refresh_ack;

    modport master (
        output req, we, addr, din, refresh_req,
        input  ack, dout, valid, refresh_ack
    );

    modport slave (
        input  req, we, addr, din, refresh_req,
        output ack, dout, valid, refresh_ack
    );

endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Combinational round-robin picker: first requesting channel at or after rr_ptr.
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] rr_ptr,
    output logic [NCH-1:0]         grant,
    output logic                   any
);

    localparam int PW = $clog2(NCH);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NCH);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-command SDRAM driver between NCH request channels; refresh wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NCH  = MEM_NCH,
    parameter int AW   = MEM_AW,
    parameter int DW   = MEM_DW,
    parameter int SLOT = MEM_SLOT
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave chan,
    output logic [AW:0]       mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_refresh,
    output logic [DW-1:0]     mem_din,
    input  logic [DW-1:0]     mem_dout,
    input  logic              mem_busy,
    input  logic              mem_data_ready,
    output logic              fail,
    output logic              busy
);

    localparam int PW = $clog2(NCH);
    localparam int CW = $clog2(SLOT + 1);

    state_t            state, next_state;
    op_t               cur_op;
    logic [PW-1:0]     rr_ptr, cur_ch, gnt_idx;
    logic [CW-1:0]     cnt;
    logic              turnaround;
    logic [NCH-1:0]    grant;
    logic              any_req;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_din;
    logic              sel_we;
    logic              do_refresh, do_grant, slot_end;
    logic [NCH-1:0]    ack_r, valid_r;
    logic [NCH*DW-1:0] dout_r;
    logic              refresh_ack_r;

    rr_arbiter #(.NCH(NCH)) u_rr (
        .req    (chan.req),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .any    (any_req)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= INIT;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            INIT:    if (!mem_busy) next_state = IDLE;
            IDLE:    if (do_refresh || do_grant) next_state = RUN;
            RUN:     if (slot_end) next_state = IDLE;
            default: next_state = INIT;
        endcase
    end

    // The first IDLE cycle after a slot is a turnaround gap for the driver,
    // giving one operation per SLOT+2 cycles.
    always_comb begin
        do_refresh = (state == IDLE) && !turnaround && chan.refresh_req;
        do_grant   = (state == IDLE) && !turnaround && !chan.refresh_req && any_req;
        slot_end   = (state == RUN) && (cnt == CW'(SLOT));
        busy       = (state != IDLE);
    end

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_din  = '0;
        sel_we   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                gnt_idx  = PW'(i);
                sel_addr = chan.addr[i*AW +: AW];
                sel_din  = chan.din[i*DW +: DW];
                sel_we   = chan.we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= '0;
            rr_ptr     <= '0;
            cur_ch     <= '0;
            cur_op     <= OP_RD;
            turnaround <= 1'b0;
        end else begin
            turnaround <= slot_end;
            if (do_refresh) begin
                cur_op <= OP_REF;
                cnt    <= CW'(1);
            end else if (do_grant) begin
                cur_ch <= gnt_idx;
                cur_op <= op_of(sel_we);
                cnt    <= CW'(1);
                rr_ptr <= (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (state == RUN && !slot_end) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ack_r         <= '0;
            refresh_ack_r <= 1'b0;
            valid_r       <= '0;
            dout_r        <= '0;
            mem_rd        <= 1'b0;
            mem_wr        <= 1'b0;
            mem_refresh   <= 1'b0;
            mem_addr      <= '0;
            mem_din       <= '0;
            fail          <= 1'b0;
        end else begin
            ack_r         <= '0;
            refresh_ack_r <= 1'b0;
            valid_r       <= '0;
            mem_rd        <= 1'b0;
            mem_wr        <= 1'b0;
            mem_refresh   <= 1'b0;
            if (do_refresh) begin
                mem_refresh   <= 1'b1;
                refresh_ack_r <= 1'b1;
            end
            if (do_grant) begin
                ack_r    <= grant;
                mem_rd   <= !sel_we;
                mem_wr   <= sel_we;
                mem_addr <= {1'b0, sel_addr};
                mem_din  <= sel_din;
            end
            // A late data-ready still delivers the sampled byte but latches the error.
            if (slot_end && cur_op == OP_RD) begin
                valid_r[cur_ch] <= 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    if (cur_ch == PW'(i)) dout_r[i*DW +: DW] <= mem_dout;
                end
                if (!mem_data_ready) fail <= 1'b1;
            end
        end
    end

    assign chan.ack         = ack_r;
    assign chan.valid       = valid_r;
    assign chan.dout        = dout_r;
    assign chan.refresh_ack = refresh_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with directed reset and fault cases.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NCH  = 4;
    localparam int AW   = 22;
    localparam int DW   = 8;
    localparam int SLOT = 4;
    localparam int GAP  = SLOT + 2;

    typedef struct {
        int           kind;
        int           ch;
        int           when;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit           wr;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW:0]   mem_addr;
    logic          mem_rd, mem_wr, mem_refresh;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic          mem_busy, mem_data_ready;
    logic          fail, busy;

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    int            rr = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ext_mem [int];
    logic [DW-1:0] ref_dout [NCH];
    logic [AW-1:0] s_addr [NCH];
    logic [DW-1:0] s_din [NCH];

    mem_port_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) chan ();

    mem_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .SLOT(SLOT)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .chan           (chan.slave),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_refresh    (mem_refresh),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_busy       (mem_busy),
        .mem_data_ready (mem_data_ready),
        .fail           (fail),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Unwritten locations read back a fixed address-derived byte.
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h4A;
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return pattern(a);
    endfunction

    always @(posedge clk) begin
        if (mem_rd) mem_dout <= ext_mem.exists(int'(mem_addr[AW-1:0])) ?
                                ext_mem[int'(mem_addr[AW-1:0])] : pattern(mem_addr[AW-1:0]);
        if (mem_wr) ext_mem[int'(mem_addr[AW-1:0])] = mem_din;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic pop_check(input int kind, input int ch);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected event: kind %0d channel %0d at cycle %0d, none required", kind, ch, cyc);
            return;
        end
        e = exp_q.pop_front();
        check_output("event kind", 64'(kind), 64'(e.kind));
        check_output("event channel", 64'(ch), 64'(e.ch));
        check_output("event cycle", 64'(cyc), 64'(e.when));
        if (kind == 0) begin
            check_output("mem_rd", 64'(mem_rd), 64'(!e.wr));
            check_output("mem_wr", 64'(mem_wr), 64'(e.wr));
            check_output("mem_addr", 64'(mem_addr), 64'({1'b0, e.addr}));
            if (e.wr) check_output("mem_din", 64'(mem_din), 64'(e.data));
        end else if (kind == 1) begin
            check_output("read data", 64'(chan.dout[ch*DW +: DW]), 64'(e.data));
        end else begin
            check_output("mem_refresh", 64'(mem_refresh), 64'(1));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NCH; i++) if (chan.ack[i]) pop_check(0, i);
            for (int i = 0; i < NCH; i++) if (chan.valid[i]) pop_check(1, i);
            if (chan.refresh_ack) pop_check(2, 0);
        end
    end

    // Predicts the whole grant sequence, then drives requests and drops each on its ack.
    task automatic apply_stimulus(input logic [NCH-1:0] mask, input logic [NCH-1:0] wmask, input bit rf);
        logic [NCH-1:0] pending;
        logic [DW-1:0]  d;
        bit             rf_p;
        int             t, last, ch, n;
        pending = mask;
        rf_p    = rf;
        t       = cyc + 1;
        last    = cyc - 5;
        while (pending != '0 || rf_p) begin
            if (rf_p) begin
                exp_q.push_back('{kind: 2, ch: 0, when: t, addr: '0, data: '0, wr: 1'b0});
                rf_p = 1'b0;
            end else begin
                ch = -1;
                for (int j = 0; j < NCH; j++)
                    if (ch < 0 && pending[(rr + j) % NCH]) ch = (rr + j) % NCH;
                pending[ch] = 1'b0;
                rr = (ch + 1) % NCH;
                if (wmask[ch]) begin
                    ref_mem[int'(s_addr[ch])] = s_din[ch];
                    exp_q.push_back('{kind: 0, ch: ch, when: t, addr: s_addr[ch], data: s_din[ch], wr: 1'b1});
                end else begin
                    d = ref_read(s_addr[ch]);
                    exp_q.push_back('{kind: 0, ch: ch, when: t, addr: s_addr[ch], data: '0, wr: 1'b0});
                    exp_q.push_back('{kind: 1, ch: ch, when: t + SLOT, addr: s_addr[ch], data: d, wr: 1'b0});
                    ref_dout[ch] = d;
                end
            end
            last = t;
            t += GAP;
        end
        for (int i = 0; i < NCH; i++) begin
            chan.addr[i*AW +: AW] = s_addr[i];
            chan.din[i*DW +: DW]  = s_din[i];
        end
        chan.we          = wmask;
        chan.req         = mask;
        chan.refresh_req = rf;
        n = 0;
        while ((chan.req != '0 || chan.refresh_req) && n < 100) begin
            @(negedge clk);
            n++;
            chan.req = chan.req & ~chan.ack;
            if (chan.refresh_ack) chan.refresh_req = 1'b0;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake timeout: req 0x%0h still pending, required 0", chan.req);
            chan.req         = '0;
            chan.refresh_req = 1'b0;
        end
        while (cyc < last + 5) @(negedge clk);
        check_output("scoreboard drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic check_dout_all();
        for (int i = 0; i < NCH; i++)
            check_output("held dout", 64'(chan.dout[i*DW +: DW]), 64'(ref_dout[i]));
        check_output("fail clear", 64'(fail), 64'(0));
    endtask

    task automatic check_reset_outputs();
        check_output("reset ack", 64'(chan.ack), 64'(0));
        check_output("reset valid", 64'(chan.valid), 64'(0));
        check_output("reset refresh_ack", 64'(chan.refresh_ack), 64'(0));
        check_output("reset mem cmds", 64'({mem_rd, mem_wr, mem_refresh}), 64'(0));
        check_output("reset mem_addr", 64'(mem_addr), 64'(0));
        check_output("reset mem_din", 64'(mem_din), 64'(0));
        check_output("reset dout", 64'(chan.dout), 64'(0));
        check_output("reset fail", 64'(fail), 64'(0));
        check_output("reset busy", 64'(busy), 64'(1));
    endtask

    task automatic reset_model();
        rr = 0;
        for (int i = 0; i < NCH; i++) ref_dout[i] = '0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ack_seen [1:10];
        bit val_seen [1:10];
        bit fail_seen [1:10];
        logic [NCH-1:0] m, w;

        resetn = 1'b0;
        mem_busy = 1'b1;
        mem_data_ready = 1'b1;
        chan.req = '0;
        chan.we = '0;
        chan.addr = '0;
        chan.din = '0;
        chan.refresh_req = 1'b0;
        reset_model();
        for (int i = 0; i < NCH; i++) begin
            s_addr[i] = '0;
            s_din[i] = '0;
        end

        repeat (3) @(negedge clk);
        check_reset_outputs();
        resetn = 1'b1;
        chan.req = 4'b0001;
        repeat (10) begin
            @(negedge clk);
            check_output("init busy", 64'(busy), 64'(1));
            check_output("init no ack", 64'(chan.ack), 64'(0));
        end
        chan.req = '0;
        mem_busy = 1'b0;
        @(negedge clk);
        check_output("busy after init", 64'(busy), 64'(0));
        mon_en = 1'b1;

        s_addr[2] = 22'h200010;
        apply_stimulus(4'b0100, 4'b0000, 1'b0);
        check_output("ch2 read byte", 64'(chan.dout[2*DW +: DW]), 64'(8'h5A));
        check_dout_all();

        for (int i = 0; i < NCH; i++) s_addr[i] = AW'(32'h100000 + i * 16);
        apply_stimulus(4'b1111, 4'b0000, 1'b0);
        check_dout_all();

        s_addr[1] = 22'h0000F0;
        apply_stimulus(4'b0010, 4'b0000, 1'b1);
        check_dout_all();

        s_addr[0] = 22'h380000;
        s_din[0]  = 8'hA5;
        apply_stimulus(4'b0001, 4'b0001, 1'b0);
        check_dout_all();
        s_addr[3] = 22'h380000;
        apply_stimulus(4'b1000, 4'b0000, 1'b0);
        check_output("write read-back", 64'(chan.dout[3*DW +: DW]), 64'(8'hA5));

        for (int r = 0; r < 25; r++) begin
            m = NCH'($urandom_range(0, 15));
            w = NCH'($urandom_range(0, 15));
            for (int i = 0; i < NCH; i++) begin
                s_addr[i] = AW'(32'h100000 + $urandom_range(0, 7) * 16);
                s_din[i]  = DW'($urandom_range(0, 255));
            end
            apply_stimulus(m, w, ($urandom_range(0, 3) == 0));
            check_dout_all();
        end

        mon_en = 1'b0;
        mem_data_ready = 1'b0;
        s_addr[1] = 22'h100040;
        chan.addr[1*AW +: AW] = s_addr[1];
        chan.we = '0;
        chan.req = 4'b0010;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            ack_seen[n]  = chan.ack[1];
            val_seen[n]  = chan.valid[1];
            fail_seen[n] = fail;
            if (chan.ack[1]) chan.req[1] = 1'b0;
        end
        check_output("late-ready ack", 64'(ack_seen[1]), 64'(1));
        check_output("late-ready no early valid", 64'(val_seen[4]), 64'(0));
        check_output("late-ready valid", 64'(val_seen[5]), 64'(1));
        check_output("fail before sample", 64'(fail_seen[4]), 64'(0));
        check_output("fail at sample", 64'(fail_seen[5]), 64'(1));
        check_output("fail sticky", 64'(fail_seen[10]), 64'(1));
        check_output("late-ready dout", 64'(chan.dout[1*DW +: DW]), 64'(ref_read(s_addr[1])));
        mem_data_ready = 1'b1;

        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        resetn = 1'b1;
        reset_model();
        @(negedge clk);

        s_addr[3] = 22'h100070;
        chan.addr[3*AW +: AW] = s_addr[3];
        chan.req = 4'b1000;
        @(negedge clk);
        check_output("abort ack", 64'(chan.ack[3]), 64'(1));
        chan.req = '0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        resetn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_output("abort no valid", 64'(chan.valid), 64'(0));
        end
        check_output("abort dout", 64'(chan.dout), 64'(0));

        mon_en = 1'b1;
        for (int i = 0; i < NCH; i++) s_addr[i] = AW'(32'h100000 + i * 32);
        apply_stimulus(4'b1010, 4'b0000, 1'b0);
        check_dout_all();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised SDRAM access arbiter that connects NCH independent NES-side request channels (CPU, PPU, loader, save-RAM DMA, …) to the single-command `sdram` driver. It replaces the fixed two-reader bridge. Each channel has its own request/acknowledge handshake, its own read-data holding register and its own data-valid strobe. Channels are served in round-robin order, and refresh has absolute priority.

## Interface
Parameters:
- NCH, 4, number of request channels (2..8)
- AW, 22, byte address width
- DW, 8, data width per channel
- SLOT, 4, cycles from command issue to data sample; also the fixed occupancy of a write or refresh

Ports (reset: resetn, synchronous, active-low; clock: clk):
- clk  in  1  main logic clock
- resetn  in  1  synchronous active-low reset
- req  in  NCH  per-channel request, held until ack
- we  in  NCH  per-channel write (1) / read (0), valid with req
- addr  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
- din  in  NCH*DW  per-channel write data
- ack  out  NCH  one-cycle pulse: request accepted
- dout  out  NCH*DW  per-channel last read data, held
- valid  out  NCH  one-cycle pulse: dout slice updated
- refresh_req  in  1  refresh request, held until refresh_ack
- refresh_ack  out  1  one-cycle pulse: refresh issued
- mem_addr  out  AW+1  address to driver, MSB always 0
- mem_rd, mem_wr, mem_refresh  out  1 each  one-cycle command pulses
- mem_din  out  DW  write data to driver
- mem_dout  in  DW  read data from driver
- mem_busy  in  1  driver busy (initialisation)
- mem_data_ready  in  1  driver data-ready
- fail  out  1  sticky timing-error flag
- busy  out  1  high in every state except IDLE

## Operation
State machine states: INIT, IDLE, RUN.
- INIT: entered on reset. Leave for IDLE on the first cycle mem_busy = 0.
- IDLE, grant decision:
  - refresh_req wins over all channels.
  - Otherwise, grant the lowest channel index ≥ rr_ptr with req = 1, wrapping modulo NCH.
  - With no request, stay in IDLE.
- On grant, register for one cycle:
  - the mem_* command (mem_rd = ~we, mem_wr = we, or mem_refresh);
  - mem_addr = {1'b0, addr slice} and mem_din;
  - the ack bit or refresh_ack.
- Also on grant: store the granted index and operation type, cnt := 1, go to RUN.
- rr_ptr := granted + 1 mod NCH on a channel grant. A refresh grant leaves rr_ptr unchanged.
- RUN: cnt increments each cycle. When cnt = SLOT, go to IDLE. For a read, on that same cycle:
  - dout[granted] := mem_dout;
  - valid[granted] pulses;
  - if mem_data_ready = 0, fail := 1.
- Writes and refresh simply time out at SLOT; they produce no valid and leave dout unchanged.
- Requests arriving during INIT or RUN wait. A channel must keep req, we, addr and din stable until its ack.
- Reset at any time:
  - state := INIT;
  - clears ack, valid, refresh_ack, mem_* commands, fail, rr_ptr and cnt;
  - any in-flight read is abandoned with no valid pulse;
  - dout is reset to 0.

## Timing
- Request seen in IDLE at edge T: command pulse and ack are high during cycle T+1.
- Read data: dout updated and valid high during cycle T+1+SLOT.
- Next grant is decided in IDLE at edge T+1+SLOT+1, so sustained throughput is one operation per SLOT+2 cycles.
- ack, valid and command outputs are registered. They are never combinational from req.
- A channel that deasserts req before ack is simply never granted; no error is raised.
- Refresh held continuously starves channels. This is accepted by design; the refresh source rate-limits itself.
- Reset values: all outputs are 0 except busy = 1.

## Structure
- Package `mem_arb_pkg`:
  - state enum {INIT, IDLE, RUN};
  - op enum {OP_RD, OP_WR, OP_REF};
  - default constants MEM_NCH, MEM_AW, MEM_DW, MEM_SLOT.
- Sub-module `rr_arbiter` (parameter NCH): combinational one-hot grant from req and rr_ptr, plus an any-request flag. The top level holds rr_ptr.
- The top level instantiates `rr_arbiter` and the FSM. The `sdram` driver stays outside this block.

## Test plan
- Reset with mem_busy = 1 for 10 cycles: busy = 1 and no ack throughout. After mem_busy falls, busy drops on the next cycle.
- Read on channel 2 of address 0x2000_10, model returns 0x5A with SLOT = 4:
  - ack[2] at T+1 with mem_rd = 1 and mem_addr = 0x0200010;
  - valid[2] at T+5 with dout slice 2 = 0x5A;
  - fail = 0.
- Channels 0..3 all held requesting: acks occur in order 0, 1, 2, 3, 0, spaced 6 cycles apart.
- refresh_req and req[1] asserted on the same edge: refresh_ack first, ack[1] six cycles later, and rr_ptr unchanged by the refresh.
- Write on channel 0 of 0xA5 to 0x380000: mem_wr pulse with mem_din = 0xA5, no valid pulse, dout unchanged.
- Two fault cases:
  - read with mem_data_ready held 0: fail rises at T+5 and stays high;
  - reset asserted at T+3 of a read: no valid pulse, and all outputs reset.
